// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/data arbiter driving a single RAM port
// Optional feature macro: MEM_TIMEOUT_EN (abort a BUSY access after TIMEOUT_CYCLES cycles with err).
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        mem_mov,
  output logic        mem_rw,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_mar,
  output logic [31:0] mem_datain,
  input  logic        mem_moc,
  input  logic [31:0] mem_dataout
);

  typedef enum logic [1:0] {IDLE, BUSY, RECOVER} state_t;

  state_t state, state_next;
  logic   last_data;  // 1 when the data port was granted most recently
  logic   gnt_data;
  logic   pick_data;
  logic   grant;
  logic   done;
  logic   abort;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          err_q;

  assign abort = (state == BUSY) && !mem_moc && (cnt == CNT_LAST);
  assign err   = err_q;

  // cnt holds the number of BUSY edges already spent without completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= abort;
      if (state != BUSY)
        cnt <= '0;
      else if (!mem_moc)
        cnt <= cnt + 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign abort          = 1'b0;
  assign err            = 1'b0;
`endif

  assign pick_data = d_req && (!if_req || !last_data);
  assign grant     = (state == IDLE) && (if_req || d_req);
  assign done      = (state == BUSY) && (mem_moc || abort);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (if_req || d_req) state_next = BUSY;
      BUSY:    if (done) state_next = RECOVER;
      RECOVER: if (!mem_moc) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_data  <= 1'b0;
      gnt_data   <= 1'b0;
      mem_mov    <= 1'b0;
      mem_rw     <= 1'b0;
      mem_size   <= 2'b00;
      mem_mar    <= '0;
      mem_datain <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      if (grant) begin
        gnt_data   <= pick_data;
        last_data  <= pick_data;
        mem_mov    <= 1'b1;
        mem_mar    <= pick_data ? d_addr : if_addr;
        mem_datain <= pick_data ? d_wdata : '0;
        mem_rw     <= pick_data ? d_rw : 1'b1;
        mem_size   <= pick_data ? d_size : 2'b10;
      end
      if (done) begin
        mem_mov <= 1'b0;
        if_ack  <= !gnt_data;
        d_ack   <= gnt_data;
        if (gnt_data)
          d_rdata <= (mem_rw && !abort) ? mem_dataout : '0;
        else
          if_rdata <= abort ? '0 : mem_dataout;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: BUSY cycles allowed before abort (used only with MEM_TIMEOUT_EN).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 if_req  input  1  fetch request, held until if_ack.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_ack  output  1  one-cycle fetch completion pulse.
REQ-007 if_rdata  output  32  fetched word, valid while if_ack=1.
REQ-008 d_req  input  1  data request, held until d_ack.
REQ-009 d_rw  input  1  data direction, 1=read, 0=write.
REQ-010 d_size  input  2  access size: 00 byte, 01 halfword, 10 word.
REQ-011 d_addr / d_wdata  input  32 each  data address / write data.
REQ-012 d_ack  output  1  one-cycle data completion pulse.
REQ-013 d_rdata  output  32  read data, valid while d_ack=1.
REQ-014 err  output  1  access aborted; valid with the accompanying ack.
REQ-015 mem_mov  output  1  memory operation valid to RAM.
REQ-016 mem_rw / mem_size  output  1 / 2  RAM direction and size (fetch: rw=1, size=10).
REQ-017 mem_mar / mem_datain  output  32 each  RAM address and write data.
REQ-018 mem_moc  input  1  RAM operation complete.
REQ-019 mem_dataout  input  32  RAM read data.

Function
REQ-020 FSM states: IDLE, BUSY, RECOVER.
REQ-021 IDLE: on an edge sampling any request, register the winner's address, data, rw and size onto the mem_* outputs, set mem_mov=1, go BUSY.
REQ-022 Arbitration: with one requester, it wins; with both, the requester not served last wins (round-robin); the last-served pointer resets to fetch, so data wins the first conflict.
REQ-023 BUSY: mem_mar, mem_datain, mem_rw and mem_size are held stable while mem_mov=1.
REQ-024 BUSY: on an edge sampling mem_moc=1, set mem_mov=0, pulse the granted ack for exactly one cycle, capture mem_dataout into the granted rdata on reads (else 0), and go RECOVER.
REQ-025 RECOVER: stay until an edge samples mem_moc=0, then go IDLE; ack is already low.
REQ-026 Minimum latency: request sampled at edge N, mem_mov high after N, ack high after N+1 if mem_moc=1 at N+1.
REQ-027 Back-to-back: at most one ack per requester per transaction; the next grant occurs no earlier than the edge after RECOVER exits.
REQ-028 A request dropped before grant is ignored; the request of the non-granted requester is not latched.
REQ-029 mem_moc high while IDLE is ignored.

Reset
REQ-030 Reset asserted: state IDLE, mem_mov=0, all acks, err, rdata and mem_* outputs 0, pointer=fetch, immediately and independent of clk.
REQ-031 Reset mid-BUSY aborts the access with no ack; after release, pending requests re-arbitrate from IDLE.

Configuration
REQ-032 With MEM_TIMEOUT_EN defined: BUSY counts cycles; after TIMEOUT_CYCLES edges without mem_moc, set mem_mov=0, pulse the ack with err=1 and rdata=0, then go RECOVER; the counter clears on entering BUSY.
REQ-033 Without MEM_TIMEOUT_EN: BUSY waits indefinitely, no counter logic is synthesized, and err is tied to 0.

Verification
REQ-034 Fetch only, if_addr=0x00000004, mem_moc after 2 cycles, mem_dataout=0x8C220000 -> if_ack one cycle, if_rdata=0x8C220000, mem_rw=1, mem_size=10.
REQ-035 Simultaneous if_req and d_req after reset -> data granted first, then fetch; the next conflict grants data (alternation).
REQ-036 Data write with d_addr=0x00000010, d_wdata=0xDEADBEEF, d_size=00 -> mem_datain=0xDEADBEEF, mem_rw=0 until moc, then d_ack=1 and d_rdata=0.
REQ-037 mem_moc held high 3 cycles after completion -> RECOVER holds, no new mem_mov until moc falls; a single d_ack.
REQ-038 Reset asserted mid-BUSY -> mem_mov=0 without a clock edge, no ack; after release, a held if_req is served.
REQ-039 MEM_TIMEOUT_EN with TIMEOUT_CYCLES=15 and mem_moc never high -> after 15 BUSY cycles, ack=1, err=1, rdata=0; without the macro, mem_mov stays high.
